vga_rect_fill_ctrl: RTL and testbench
=====================================

VGA_RECT_FILL_CTRL -- requirements
Module: vga_rect_fill_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command buffer depth (power of 2, >=2).
REQ-002 SHALL have parameter SCREEN_W, default 160, visible columns.
REQ-003 SHALL have parameter SCREEN_H, default 120, visible rows.
REQ-004 CLOCK_50  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  requester presents a fill command.
REQ-007 cmd_ready  output  1  block can accept a command this cycle.
REQ-008 cmd_x  input  8  rectangle left column.
REQ-009 cmd_y  input  7  rectangle top row.
REQ-010 cmd_w  input  8  width in pixels.
REQ-011 cmd_h  input  7  height in pixels.
REQ-012 cmd_color  input  3  fill colour (0-7).
REQ-013 VGA_X  output  8  pixel column.
REQ-014 VGA_Y  output  7  pixel row.
REQ-015 VGA_COLOR  output  3  pixel colour.
REQ-016 plot  output  1  pixel at VGA_X/VGA_Y written this cycle.
REQ-017 busy  output  1  FIFO non-empty or engine not IDLE.
REQ-018 done  output  1  one-cycle pulse per completed or discarded command.

Function
REQ-019 Command SHALL be accepted on a cycle with cmd_valid && cmd_ready; cmd_ready = FIFO not full, independent of cmd_valid.
REQ-020 On a full FIFO a same-cycle pop SHALL NOT raise cmd_ready in that cycle.
REQ-021 Engine states SHALL be IDLE, LOAD, FILL, DONE.
REQ-022 IDLE: FIFO non-empty -> pop head, go LOAD; else stay.
REQ-023 LOAD: compute x_end = min(x+w, SCREEN_W)-1 in 9 bits, y_end = min(y+h, SCREEN_H)-1 in 8 bits; w==0, h==0, x>=SCREEN_W or y>=SCREEN_H -> DONE with no plot; else set pixel counters to (x,y), go FILL.
REQ-024 FILL: plot=1 every cycle, raster order, x fastest; at x_end wrap x to cmd x and increment y; after pixel (x_end,y_end) go DONE.
REQ-025 Clipping SHALL apply to right and bottom edges only; no pixel outside 0..SCREEN_W-1 / 0..SCREEN_H-1 is ever plotted.
REQ-026 Pixel stream SHALL be contiguous: exactly clipped_w*clipped_h consecutive plot cycles, no gaps.
REQ-027 DONE: done=1 for exactly that cycle, plot=0, go IDLE.
REQ-028 Latency: with empty FIFO and IDLE engine, first plot SHALL occur 3 cycles after the handshake cycle; between commands plot SHALL be low for exactly 3 cycles (DONE, IDLE, LOAD).
REQ-029 VGA_X, VGA_Y, VGA_COLOR, plot, done SHALL be registered outputs; VGA_* hold last value when plot=0.
REQ-030 Commands SHALL execute in acceptance order; accepted commands are never dropped except by reset.

Reset
REQ-031 reset SHALL force state IDLE, flush FIFO, VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, done=0, busy=0 on the next edge.
REQ-032 Reset mid-FILL SHALL abort the rectangle with no done pulse; cmd_ready=1 in the first cycle after reset.
REQ-033 A command presented during reset SHALL NOT be accepted.

Structure
REQ-034 Shared package vga_pkg SHALL hold SCREEN_W, SCREEN_H, coordinate/colour widths, the fill-command struct typedef and the engine state enum.
REQ-035 Command buffering SHALL be sub-module vga_cmd_fifo (synchronous, registered, FIFO_DEPTH entries of the command struct, full/empty flags).

Verification
REQ-036 Cmd (10,20,w=3,h=2,color=5) -> 6 plot cycles: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 5, then one done.
REQ-037 Cmd (158,118,w=5,h=5) -> 4 pixels (158,118),(159,118),(158,119),(159,119), one done.
REQ-038 Cmd w=0 or x=200 -> no plot, exactly one done pulse.
REQ-039 Push 5 commands back-to-back with FIFO_DEPTH=4 and engine stalled in a long fill -> cmd_ready low after 4 buffered (first already popped), all 5 executed in order, 5 done pulses.
REQ-040 Reset asserted mid-fill of (0,0,160,120) -> plot=0 next cycle, no done, busy=0, subsequent cmd (0,0,1,1) plots (0,0) only.
REQ-041 Full-screen cmd (0,0,160,120) -> exactly 19200 consecutive plot cycles, last pixel (159,119).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the rectangle-fill VGA path: screen size,
// coordinate/colour widths, the fill command and engine states.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [C_W-1:0] color;
    } fill_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE
    } eng_state_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous FIFO of fill commands with registered storage.
// Ports: push/push_data in, pop in, head out, full/empty flags.
module vga_cmd_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      CLOCK_50,
    input  logic      reset,
    input  logic      push,
    input  fill_cmd_t push_data,
    input  logic      pop,
    output fill_cmd_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    fill_cmd_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle fill engine: buffers commands, then streams one clipped
// pixel per cycle. Ports: cmd_* handshake in, VGA_* / plot / done / busy out.
module vga_rect_fill_ctrl
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = vga_pkg::SCREEN_W,
    parameter int SCREEN_H   = vga_pkg::SCREEN_H
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [X_W-1:0] cmd_x,
    input  logic [Y_W-1:0] cmd_y,
    input  logic [X_W-1:0] cmd_w,
    input  logic [Y_W-1:0] cmd_h,
    input  logic [C_W-1:0] cmd_color,
    output logic [X_W-1:0] VGA_X,
    output logic [Y_W-1:0] VGA_Y,
    output logic [C_W-1:0] VGA_COLOR,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

    eng_state_t     state;
    fill_cmd_t      cur;
    fill_cmd_t      push_data;
    fill_cmd_t      head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           fifo_push;
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;
    logic [X_W:0]   x_sum;
    logic [Y_W:0]   y_sum;
    logic [X_W:0]   x_end_n;
    logic [Y_W:0]   y_end_n;
    logic           skip;
    logic           at_x_end;
    logic           at_y_end;

    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);

    assign push_data.x     = cmd_x;
    assign push_data.y     = cmd_y;
    assign push_data.w     = cmd_w;
    assign push_data.h     = cmd_h;
    assign push_data.color = cmd_color;

    vga_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Clip against right/bottom edges; one extra bit holds the carry.
    always_comb begin
        x_sum   = {1'b0, cur.x} + {1'b0, cur.w};
        y_sum   = {1'b0, cur.y} + {1'b0, cur.h};
        x_end_n = ((x_sum > SW) ? SW : x_sum) - (X_W+1)'(1);
        y_end_n = ((y_sum > SH) ? SH : y_sum) - (Y_W+1)'(1);
        skip    = (cur.w == '0) || (cur.h == '0) ||
                  ({1'b0, cur.x} >= SW) || ({1'b0, cur.y} >= SH);
    end

    assign at_x_end = ({1'b0, VGA_X} == x_end);
    assign at_y_end = ({1'b0, VGA_Y} == y_end);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            x_end     <= '0;
            y_end     <= '0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            plot      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= head;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (skip) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        x_end     <= x_end_n;
                        y_end     <= y_end_n;
                        VGA_X     <= cur.x;
                        VGA_Y     <= cur.y;
                        VGA_COLOR <= cur.color;
                        plot      <= 1'b1;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // VGA_X/VGA_Y double as the raster counters.
                    if (at_x_end) begin
                        if (at_y_end) begin
                            plot  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            VGA_X <= cur.x;
                            VGA_Y <= VGA_Y + Y_W'(1);
                        end
                    end else begin
                        VGA_X <= VGA_X + X_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Self-checking bench for vga_rect_fill_ctrl: behavioural event-queue
// model, per-cycle compare, directed cases and randomized commands.
module tb_vga_rect_fill_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x = '0;
    logic [6:0] cmd_y = '0;
    logic [7:0] cmd_w = '0;
    logic [6:0] cmd_h = '0;
    logic [2:0] cmd_color = '0;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot;
    logic       busy;
    logic       done;

    vga_rect_fill_ctrl #(
        .FIFO_DEPTH (4),
        .SCREEN_W   (160),
        .SCREEN_H   (120)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Expected event stream: every pixel of every accepted command in
    // order, followed by that command's done marker.
    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
        bit first;
        int acc;
    } ev_t;

    ev_t expq[$];
    int  outstanding = 0;
    int  last_done   = -100;
    int  last_ev_cyc = 0;
    int  hold_x = 0, hold_y = 0, hold_c = 0;
    int  plog_x[$], plog_y[$], plog_c[$], plog_cyc[$];
    int  done_cnt = 0;
    int  plot_cnt = 0;

    function automatic void model_accept(int x, int y, int w, int h,
                                         int c, int acc);
        ev_t e;
        int  xe, ye;
        bit  first;
        xe = (x + w > 160) ? 160 : x + w;
        ye = (y + h > 120) ? 120 : y + h;
        first = 1'b1;
        if (!(w == 0 || h == 0 || x >= 160 || y >= 120)) begin
            for (int yy = y; yy < ye; yy++)
                for (int xx = x; xx < xe; xx++) begin
                    e = '{1'b0, xx, yy, c, first, acc};
                    expq.push_back(e);
                    first = 1'b0;
                end
        end
        e = '{1'b1, 0, 0, 0, first, acc};
        expq.push_back(e);
    endfunction

    always @(negedge CLOCK_50) begin
        ev_t e;
        int  exp_cyc;
        bit  exp_now;
        if (cyc >= 1) begin
            exp_now = 1'b0;
            if (expq.size() > 0) begin
                if (expq[0].first)
                    exp_cyc = ((expq[0].acc > last_done) ?
                               expq[0].acc : last_done) + 3;
                else
                    exp_cyc = last_ev_cyc + 1;
                exp_now = (cyc == exp_cyc);
            end
            chk("event_timing", 32'(plot || done), 32'(exp_now));
            chk("plot_done_excl", 32'(plot && done), 0);
            chk("busy", 32'(busy), 32'(outstanding > 0));
            if ((plot || done) && expq.size() > 0) begin
                e = expq.pop_front();
                chk("event_kind", 32'(done), 32'(e.is_done));
                if (!e.is_done) begin
                    chk("pix_x", 32'(VGA_X), e.x);
                    chk("pix_y", 32'(VGA_Y), e.y);
                    chk("pix_c", 32'(VGA_COLOR), e.c);
                end
                last_ev_cyc = cyc;
                if (e.is_done) begin
                    last_done = cyc;
                    outstanding--;
                end
            end
            if (plot) begin
                hold_x = VGA_X;
                hold_y = VGA_Y;
                hold_c = VGA_COLOR;
                plog_x.push_back(VGA_X);
                plog_y.push_back(VGA_Y);
                plog_c.push_back(VGA_COLOR);
                plog_cyc.push_back(cyc);
                plot_cnt++;
            end else begin
                chk("hold_x", 32'(VGA_X), hold_x);
                chk("hold_y", 32'(VGA_Y), hold_y);
                chk("hold_c", 32'(VGA_COLOR), hold_c);
            end
            if (done)
                done_cnt++;
            if (reset) begin
                chk("ready_in_reset", 32'(cmd_ready), 0);
                expq.delete();
                outstanding = 0;
                last_done   = -100;
                hold_x = 0;
                hold_y = 0;
                hold_c = 0;
            end else if (cmd_valid && cmd_ready) begin
                model_accept(cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cyc);
                outstanding++;
            end
        end
    end

    task automatic clear_logs();
        plog_x.delete();
        plog_y.delete();
        plog_c.delete();
        plog_cyc.delete();
        done_cnt = 0;
        plot_cnt = 0;
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the handshake.
    task automatic send(input int x, input int y, input int w,
                        input int h, input int c, output int hs);
        int t;
        t = 0;
        hs = -1;
        cmd_x = 8'(x);
        cmd_y = 7'(y);
        cmd_w = 8'(w);
        cmd_h = 7'(h);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
        forever begin
            @(negedge CLOCK_50);
            if (cmd_ready) begin
                hs = cyc;
                break;
            end
            t++;
            if (t > 30000) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge CLOCK_50);
            t++;
        end while (busy && t < 40000);
        if (busy)
            chk("idle_timeout", 0, 1);
        @(posedge CLOCK_50);
        #1;
    endtask

    int hs;
    int d0;
    int ex36[6] = '{10, 11, 12, 10, 11, 12};
    int ey36[6] = '{20, 20, 20, 21, 21, 21};
    int ex37[4] = '{158, 159, 158, 159};
    int ey37[4] = '{118, 118, 119, 119};

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vga_x", 32'(VGA_X), 0);
        chk("rst_vga_y", 32'(VGA_Y), 0);
        chk("rst_color", 32'(VGA_COLOR), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        @(posedge CLOCK_50);
        #1;

        // 3x2 rectangle, colour 5
        clear_logs();
        send(10, 20, 3, 2, 5, hs);
        wait_idle();
        chk("r36_npix", plog_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("r36_x", plog_x[i], ex36[i]);
            chk("r36_y", plog_y[i], ey36[i]);
            chk("r36_c", plog_c[i], 5);
        end
        chk("r36_latency", plog_cyc[0], hs + 3);
        chk("r36_done", done_cnt, 1);

        // corner clip
        clear_logs();
        send(158, 118, 5, 5, 2, hs);
        wait_idle();
        chk("r37_npix", plog_x.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("r37_x", plog_x[i], ex37[i]);
            chk("r37_y", plog_y[i], ey37[i]);
        end
        chk("r37_done", done_cnt, 1);

        // discarded commands
        clear_logs();
        send(5, 5, 0, 4, 1, hs);
        wait_idle();
        send(200, 5, 4, 4, 1, hs);
        wait_idle();
        chk("r38_plots", plot_cnt, 0);
        chk("r38_done", done_cnt, 2);

        // five back-to-back pushes behind a long fill
        clear_logs();
        send(0, 0, 160, 20, 1, hs);
        send(1, 1, 2, 1, 2, hs);
        send(2, 2, 1, 2, 3, hs);
        send(150, 100, 20, 30, 4, hs);
        send(5, 5, 1, 1, 7, hs);
        @(negedge CLOCK_50);
        chk("r39_full", 32'(cmd_ready), 0);
        @(posedge CLOCK_50);
        #1;
        wait_idle();
        chk("r39_done", done_cnt, 5);
        chk("r39_plots", plot_cnt, 3405);

        // reset in mid fill, command presented during reset
        clear_logs();
        send(0, 0, 160, 120, 6, hs);
        repeat (300) @(posedge CLOCK_50);
        #1;
        d0 = done_cnt;
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_x = 8'd3;
        cmd_y = 7'd3;
        cmd_w = 8'd2;
        cmd_h = 7'd2;
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        chk("r40_plot", 32'(plot), 0);
        chk("r40_busy", 32'(busy), 0);
        chk("r40_ready", 32'(cmd_ready), 1);
        @(posedge CLOCK_50);
        #1;
        chk("r40_nodone", done_cnt, d0);
        clear_logs();
        send(0, 0, 1, 1, 4, hs);
        wait_idle();
        chk("r40_npix", plot_cnt, 1);
        chk("r40_px", plog_x[0], 0);
        chk("r40_py", plog_y[0], 0);
        chk("r40_done", done_cnt, 1);

        // full screen
        clear_logs();
        send(0, 0, 160, 120, 3, hs);
        wait_idle();
        chk("r41_npix", plot_cnt, 19200);
        chk("r41_span", plog_cyc[19199] - plog_cyc[0], 19199);
        chk("r41_last_x", plog_x[19199], 159);
        chk("r41_last_y", plog_y[19199], 119);
        chk("r41_done", done_cnt, 1);

        // randomized commands
        for (int i = 0; i < 80; i++) begin
            int rx, ry, rw, rh;
            rx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 159)
                                              : $urandom_range(0, 255);
            ry = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 119)
                                              : $urandom_range(0, 127);
            rw = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 24)
                                              : $urandom_range(0, 255);
            rh = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 8)
                                              : $urandom_range(0, 127);
            send(rx, ry, rw, rh, $urandom_range(0, 7), hs);
            repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
            #1;
        end
        wait_idle();
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
